// File: rtl/uart_fifo_pkg.sv
// Shared defaults, trigger-select and timeout-state encodings
// for the UART FIFO pointer/status controller.
package uart_fifo_pkg;

  localparam int UART_FIFO_POINTER_W = 4;
  localparam int UART_FIFO_DEPTH     = 16;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_Q  = 2'b01,
    TRIG_H  = 2'b10,
    TRIG_NF = 2'b11
  } trig_sel_e;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'b00,
    TO_COUNT = 2'b01,
    TO_EXP   = 2'b10
  } tout_state_e;

  function automatic int unsigned trig_level(
    input logic [1:0]  sel,
    input int unsigned depth
  );
    int unsigned lvl;
    lvl = 1;
    unique case (trig_sel_e'(sel))
      TRIG_1:  lvl = 1;
      TRIG_Q:  lvl = depth / 4;
      TRIG_H:  lvl = depth / 2;
      TRIG_NF: lvl = depth - 2;
      default: lvl = 1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_tout.sv
// Character-timeout counter and FSM; asserts timeout after
// tout_load ticks with data waiting and no FIFO activity.
module uart_fifo_ctrl_tout
  import uart_fifo_pkg::*;
#(
  parameter int TOUT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act_i,
  input  logic              empty_i,
  input  logic              tick_i,
  input  logic [TOUT_W-1:0] tout_load_i,
  output logic              timeout_o
);

  tout_state_e       state_q;
  logic [TOUT_W-1:0] cnt_q;
  logic              timeout_q;
  logic              dis;

  assign dis       = (tout_load_i == '0);
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TO_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        TO_IDLE: begin
          cnt_q <= tout_load_i;
          if (!empty_i && !dis)
            state_q <= TO_COUNT;
        end
        TO_COUNT: begin
          if (empty_i || dis) begin
            state_q <= TO_IDLE;
            cnt_q   <= tout_load_i;
          end else if (act_i) begin
            cnt_q <= tout_load_i;
          end else if (tick_i) begin
            if (cnt_q <= TOUT_W'(1)) begin
              state_q   <= TO_EXP;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - TOUT_W'(1);
            end
          end
        end
        TO_EXP: begin
          if (act_i || dis) begin
            state_q   <= TO_IDLE;
            timeout_q <= 1'b0;
            cnt_q     <= tout_load_i;
          end
        end
        default: begin
          state_q   <= TO_IDLE;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO pointer/occupancy/status controller for an external RAM.
// Optional RTS flow control under UART_FIFO_HWFLOW_EN.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int ADDR_W = UART_FIFO_POINTER_W,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = 8,
  parameter int TOUT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_top,
  output logic [ADDR_W-1:0] ram_bottom,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  input  logic              ovr_clr,
  input  logic [1:0]        trig_sel,
  output logic              trig_hit,
  input  logic              tick,
  input  logic [TOUT_W-1:0] tout_load,
  output logic              timeout
`ifdef UART_FIFO_HWFLOW_EN
  ,
  output logic              rts_n
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_LVL = CW'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q;
  logic [ADDR_W:0]   lvl;
  logic              do_push, do_pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  assign count = count_q;

  assign ram_top    = wptr_q;
  assign ram_bottom = rptr_q;
  assign ram_wdata  = push_data;
  assign pop_data   = ram_rdata;

  // A pop on a full FIFO frees the slot the same-cycle write lands in.
  assign ram_we  = push & (~full | pop) & ~fifo_clr;
  assign do_push = ram_we;
  assign do_pop  = pop & ~empty & ~fifo_clr;
  assign drop    = push & full & ~pop & ~fifo_clr;

  assign lvl      = CW'(trig_level(trig_sel, DEPTH));
  assign trig_hit = (count_q >= lvl);
  assign overrun  = overrun_q;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      fifo_clr:           count_d = '0;
      do_push && !do_pop: count_d = count_q + CW'(1);
      do_pop && !do_push: count_d = count_q - CW'(1);
      default:            count_d = count_q;
    endcase
  end

  assign wptr_d = fifo_clr ? '0 : wptr_q + ADDR_W'(do_push);
  assign rptr_d = fifo_clr ? '0 : rptr_q + ADDR_W'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (drop)
        overrun_q <= 1'b1;
      else if (ovr_clr)
        overrun_q <= 1'b0;
    end
  end

  uart_fifo_ctrl_tout #(
    .TOUT_W (TOUT_W)
  ) u_tout (
    .clk         (clk),
    .rst_n       (rst_n),
    .act_i       (do_push | do_pop | fifo_clr),
    .empty_i     (empty),
    .tick_i      (tick),
    .tout_load_i (tout_load),
    .timeout_o   (timeout)
  );

`ifdef UART_FIFO_HWFLOW_EN
  localparam logic [ADDR_W:0] NF_LVL = CW'(DEPTH - 2);
  logic rts_q;

  // Hysteresis between the near-full mark and the trigger level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rts_q <= 1'b0;
    else if (fifo_clr)
      rts_q <= 1'b0;
    else if (count_d >= NF_LVL)
      rts_q <= 1'b1;
    else if (count_d <= lvl)
      rts_q <= 1'b0;
  end

  assign rts_n = rts_q;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl with a behavioural RAM.
// Covers fill/drain, overrun, wrap, trigger, timeout, flush.
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_clr = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       pop = 1'b0;
  logic [7:0] pop_data;
  logic       ram_we;
  logic [3:0] ram_top, ram_bottom;
  logic [7:0] ram_wdata, ram_rdata;
  logic [4:0] count;
  logic       empty, full, overrun;
  logic       ovr_clr = 1'b0;
  logic [1:0] trig_sel = 2'b00;
  logic       trig_hit;
  logic       tick = 1'b0;
  logic [9:0] tout_load = '0;
  logic       timeout;
`ifdef UART_FIFO_HWFLOW_EN
  logic       rts_n;
  int         mrts = 0;
`endif

  logic [7:0] mem [16];
  logic [7:0] sb [$];
  int         mcount = 0;
  int         movr = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_we) mem[ram_top] <= ram_wdata;
  assign ram_rdata = mem[ram_bottom];

  uart_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_clr   (fifo_clr),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (pop_data),
    .ram_we     (ram_we),
    .ram_top    (ram_top),
    .ram_bottom (ram_bottom),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .trig_sel   (trig_sel),
    .trig_hit   (trig_hit),
    .tick       (tick),
    .tout_load  (tout_load),
    .timeout    (timeout)
`ifdef UART_FIFO_HWFLOW_EN
    ,
    .rts_n      (rts_n)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic int lvl_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  task automatic step(input logic p, input logic [7:0] d,
                      input logic q, input logic c);
    logic epop, epush, drop;
    push = p; push_data = d; pop = q; fifo_clr = c;
    #1;
    epop  = q && mcount != 0 && !c;
    epush = p && (mcount != 16 || q) && !c;
    drop  = p && mcount == 16 && !q && !c;
    if (epop) chk("pop_data", 32'(pop_data), 32'(sb.pop_front()));
    if (epush) sb.push_back(d);
    if (c) begin
      sb.delete();
      mcount = 0;
    end else begin
      mcount = mcount + int'(epush) - int'(epop);
    end
    if (drop) movr = 1;
    else if (ovr_clr) movr = 0;
`ifdef UART_FIFO_HWFLOW_EN
    if (c) mrts = 0;
    else if (mcount >= 14) mrts = 1;
    else if (mcount <= lvl_of(trig_sel)) mrts = 0;
`endif
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; fifo_clr = 1'b0;
    chk("count", 32'(count), 32'(mcount));
    chk("empty", 32'(empty), 32'(mcount == 0));
    chk("full", 32'(full), 32'(mcount == 16));
    chk("overrun", 32'(overrun), 32'(movr));
    chk("trig_hit", 32'(trig_hit), 32'(mcount >= lvl_of(trig_sel)));
`ifdef UART_FIFO_HWFLOW_EN
    chk("rts_n", 32'(rts_n), 32'(mrts));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    #22;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_tout", 32'(timeout), 32'd0);
    chk("rst_trig", 32'(trig_hit), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    #1 chk("head", 32'(pop_data), 32'h00);
    ovr_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovr_prio", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    ovr_clr = 1'b0;

    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        #1 chk("last55", 32'(pop_data), 32'h55);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    trig_sel = 2'b10;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(r * 16 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("pp_empty", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    trig_sel = 2'b00;

    tout_load = 10'd5;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      tick = 1'b0;
      chk("tout_tick", 32'(timeout), 32'(k == 4));
      for (int j = 0; j < 3; j++) step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("tout_hold", 32'(timeout), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tout_clr", 32'(timeout), 32'd0);

    tout_load = 10'd0;
    step(1'b1, 8'h3D, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick = (k % 4 == 0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (k % 8 == 7) chk("tout_off", 32'(timeout), 32'd0);
    end
    tick = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 32), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_ovr", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    ovr_clr = 1'b0;

`ifdef UART_FIFO_HWFLOW_EN
    trig_sel = 2'b01;
    for (int i = 0; i < 14; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("rts_hi", 32'(rts_n), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rts_lo", 32'(rts_n), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    trig_sel = 2'b00;
`endif

    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    sb.delete();
    mcount = 0;
    movr = 0;
`ifdef UART_FIFO_HWFLOW_EN
    mrts = 0;
`endif
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Pointer, occupancy and status controller for one UART byte FIFO.
- Drives an external dual-port RAM: synchronous write at `ram_top`, asynchronous read at `ram_bottom`.
- Generates empty/full/count, the sticky overrun flag, a 16550-style trigger-level hit and the character-timeout indication.
- One instance serves the RX path and one the TX path; the register block sits above it.

Parameters:
- ADDR_W, 4, pointer width (matches the RAM address width).
- DEPTH, 16, entries; must equal 2**ADDR_W.
- DATA_W, 8, entry width.
- TOUT_W, 10, width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_clr  in  1  synchronous flush
- push  in  1  write request
- push_data  in  DATA_W  write data
- pop  in  1  read request
- pop_data  out  DATA_W  head entry (= ram_rdata), combinational
- ram_we  out  1  RAM write enable
- ram_top  out  ADDR_W  RAM write address
- ram_bottom  out  ADDR_W  RAM read address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM async read data
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overrun  out  1  sticky: push dropped
- ovr_clr  in  1  clears overrun
- trig_sel  in  2  trigger level select
- trig_hit  out  1  count >= selected level
- tick  in  1  timeout timebase strobe (e.g. 4x baud/16)
- tout_load  in  TOUT_W  timeout reload value; 0 = timeout disabled
- timeout  out  1  character timeout

Behaviour:
- Reset: wptr=0, rptr=0, count=0, overrun=0, timeout=0, timeout state IDLE; hence empty=1, full=0, trig_hit=0.
- ram_top=wptr, ram_bottom=rptr, ram_wdata=push_data.
- ram_we = push & (~full | pop) & ~fifo_clr, combinational.
- pop_data = ram_rdata; valid whenever ~empty. A pop consumes the entry visible in the same cycle.
- Effective pop: pop & ~empty & ~fifo_clr. Effective push: ram_we.
- Pointers advance by 1 per effective op and wrap DEPTH-1 -> 0 naturally (ADDR_W-bit arithmetic).
- count is +1 on push only, -1 on pop only, unchanged on both.
- Full with push and pop in the same cycle: both accepted; the write lands at top==bottom; the async read returns the old entry; count stays DEPTH.
- Empty with push and pop in the same cycle: pop ignored, push accepted, count -> 1.
- Push when full without pop: data dropped, no pointer or count change, overrun<=1 next cycle.
- Pop when empty: ignored.
- overrun: set has priority over ovr_clr in the same cycle. fifo_clr does not affect overrun.
- fifo_clr: wptr, rptr and count <= 0 next cycle. Overrides push and pop. Also clears timeout.
- trig_hit levels, combinational from registered count:
  - trig_sel 00 -> 1
  - 01 -> DEPTH/4
  - 10 -> DEPTH/2
  - 11 -> DEPTH-2
  - (1, 4, 8, 14 at DEPTH=16)
- Timeout FSM (registered):
  - IDLE: counter=tout_load. Go to COUNT when ~empty and tout_load!=0.
  - COUNT: decrement on tick. Any effective push/pop or fifo_clr reloads the counter. Go to IDLE if empty becomes true. At counter==1 with tick, go to EXPIRED.
  - EXPIRED: timeout=1. Any effective push/pop or fifo_clr -> timeout=0, go to IDLE (reload). If tout_load becomes 0, go to IDLE.
  - timeout is asserted only in EXPIRED; it rises the cycle after the expiring tick.
- A reset mid-operation returns everything to reset values immediately (asynchronous). RAM contents are don't-care.

Optional Feature:
- Macro: UART_FIFO_HWFLOW_EN.
- Defined:
  - Adds output rts_n (1 bit, reset value 0 = asserted).
  - rts_n<=1 when count >= DEPTH-2 after an update.
  - rts_n<=0 when count <= trig level after an update.
  - Between these thresholds rts_n holds (hysteresis).
  - fifo_clr forces 0.
- Not defined: port absent, no flow-control logic.

Decomposition:
- Shared package/include:
  - UART_FIFO_POINTER_W and UART_FIFO_DEPTH defaults.
  - Trigger-select encodings TRIG_1 / TRIG_Q / TRIG_H / TRIG_NF.
  - Timeout FSM state encodings TO_IDLE / TO_COUNT / TO_EXP.
- One sub-module is natural: uart_fifo_tout, holding the timeout counter and FSM, with inputs from the effective push/pop/clr and empty.
- The RAM stays outside; the integration wrapper connects it.

Test Plan:
- Reset, then 16 pushes of 0x00..0x0F, then 16 pops. Required: full=1 after the 16th push; pop_data sequence 0x00..0x0F; empty=1 at the end; overrun=0.
- From full, push 0xAA without pop. Required: overrun=1 next cycle, count=16, head still 0x00. Then ovr_clr -> overrun=0. Assert ovr_clr and a dropped push together -> overrun=1.
- From full, push 0x55 and pop in the same cycle. Required: pop yields 0x00, count=16; the last of the next 16 pops yields 0x55.
- Wrap-around: 10 pushes, 10 pops, repeated 3 times. Required: pointers wrap, data order intact. trig_sel=10 gives trig_hit exactly while count >= 8. Push+pop when empty -> count=1.
- tout_load=5, 1 push, tick every 4 clk. Required: timeout=1 one clk after the 5th tick. A pop then clears it and returns to IDLE. With tout_load=0, timeout never asserts.
- fifo_clr with push and pop asserted at count=7 with overrun=1. Required: count=0, empty=1, overrun stays 1. With UART_FIFO_HWFLOW_EN: rts_n rises at count 14 and falls at count <= trigger level.
